// File: rtl/sik_stack_unit_if.sv
// rtl/sik_stack_unit_if.sv - op/response bus of the multi-context operand stack
interface sik_stack_unit_if #(
    parameter int WIDTH  = 16,
    parameter int DEPTHW = 8,
    parameter int CTXW   = 1
);
    localparam int CTX = 1 << CTXW;

    logic              op_valid;
    logic [CTXW-1:0]   op_ctx;
    logic [3:0]        op_code;
    logic [WIDTH-1:0]  op_data;
    logic              rsp_valid;
    logic [CTXW-1:0]   rsp_ctx;
    logic              rsp_err;
    logic [WIDTH-1:0]  rsp_data;
    logic [CTX-1:0]    err;
    logic [CTX-1:0]    empty;
    logic [CTX-1:0]    full;

    modport master (
        output op_valid, op_ctx, op_code, op_data,
        input  rsp_valid, rsp_ctx, rsp_err, rsp_data, err, empty, full
    );

    modport slave (
        input  op_valid, op_ctx, op_code, op_data,
        output rsp_valid, rsp_ctx, rsp_err, rsp_data, err, empty, full
    );
endinterface

// File: rtl/sik_stack_unit.sv
// rtl/sik_stack_unit.sv - per-context operand stack executing stack and ALU ops in place
module sik_stack_unit #(
    parameter int WIDTH  = 16,
    parameter int DEPTHW = 8,
    parameter int CTXW   = 1
) (
    input  logic            clk,
    input  logic            reset,
    sik_stack_unit_if.slave bus
);
    localparam int DEPTH = 1 << DEPTHW;
    localparam int CTX   = 1 << CTXW;
    localparam int CW    = DEPTHW + 1;
    localparam int AW    = CTXW + DEPTHW;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0, OP_PUSH = 4'd1, OP_POP = 4'd2, OP_DUP = 4'd3,
        OP_GET = 4'd4, OP_PUT = 4'd5, OP_ADD = 4'd6, OP_SUB = 4'd7,
        OP_AND = 4'd8, OP_OR  = 4'd9, OP_XOR = 4'd10, OP_LT = 4'd11,
        OP_CLR = 4'd12
    } op_e;

    logic [CW-1:0]    cnt_q [CTX];
    logic [CTX-1:0]   err_q;
    logic [WIDTH-1:0] mem_q [CTX*DEPTH];
    logic             rsp_valid_q, rsp_err_q;
    logic [CTXW-1:0]  rsp_ctx_q;
    logic [WIDTH-1:0] rsp_data_q;

    logic [CW-1:0]     cnt, cnt_d, k_ext;
    logic [DEPTHW-1:0] idx_tos, idx_nxt, idx_k, idx_top;
    logic [WIDTH-1:0]  tos, nxt, pick, res;
    logic              is_empty, is_full, k_bad, fault, clr, wr_en;
    logic [AW-1:0]     wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [CTX-1:0]    empty_w, full_w;

    assign cnt      = cnt_q[bus.op_ctx];
    assign k_ext    = {1'b0, bus.op_data[DEPTHW-1:0]};
    assign idx_top  = cnt[DEPTHW-1:0];
    assign idx_tos  = DEPTHW'(cnt - CW'(1));
    assign idx_nxt  = DEPTHW'(cnt - CW'(2));
    assign idx_k    = DEPTHW'(cnt - CW'(1) - k_ext);
    assign tos      = mem_q[{bus.op_ctx, idx_tos}];
    assign nxt      = mem_q[{bus.op_ctx, idx_nxt}];
    assign pick     = mem_q[{bus.op_ctx, idx_k}];
    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == CW'(DEPTH));
    assign k_bad    = (k_ext >= cnt);

    always_comb begin
        fault   = 1'b0;
        clr     = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        cnt_d   = cnt;
        res     = '0;
        case (bus.op_code)
            OP_NOP:  res = is_empty ? '0 : tos;
            OP_PUSH: begin
                fault = is_full;
                wr_en = 1'b1; wr_addr = {bus.op_ctx, idx_top}; wr_data = bus.op_data;
                cnt_d = cnt + CW'(1); res = bus.op_data;
            end
            OP_POP: begin
                fault = is_empty;
                cnt_d = cnt - CW'(1); res = tos;
            end
            OP_DUP: begin
                fault = is_empty | is_full;
                wr_en = 1'b1; wr_addr = {bus.op_ctx, idx_top}; wr_data = tos;
                cnt_d = cnt + CW'(1); res = tos;
            end
            OP_GET: begin
                // underflow (k_bad) is reported ahead of overflow; both simply fault
                fault = k_bad | is_full;
                wr_en = 1'b1; wr_addr = {bus.op_ctx, idx_top}; wr_data = pick;
                cnt_d = cnt + CW'(1); res = pick;
            end
            OP_PUT: begin
                fault = k_bad;
                wr_en = 1'b1; wr_addr = {bus.op_ctx, idx_k}; wr_data = tos;
                res = tos;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LT: begin
                fault = (cnt < CW'(2));
                case (bus.op_code)
                    OP_ADD:  res = nxt + tos;
                    OP_SUB:  res = nxt - tos;
                    OP_AND:  res = nxt & tos;
                    OP_OR:   res = nxt | tos;
                    OP_XOR:  res = nxt ^ tos;
                    default: res = {{(WIDTH-1){1'b0}}, ($signed(nxt) < $signed(tos))};
                endcase
                wr_en = 1'b1; wr_addr = {bus.op_ctx, idx_nxt}; wr_data = res;
                cnt_d = cnt - CW'(1);
            end
            OP_CLR: begin
                clr   = 1'b1;
                cnt_d = '0;
            end
            default: fault = 1'b1;
        endcase
        if (fault) begin
            wr_en = 1'b0;
            cnt_d = cnt;
            res   = '0;
        end
    end

    // storage is deliberately not reset; writes are still blocked while reset is low
    always_ff @(posedge clk) begin
        if (reset && bus.op_valid && wr_en)
            mem_q[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CTX; i++) cnt_q[i] <= '0;
            err_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_ctx_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= bus.op_valid;
            if (bus.op_valid) begin
                cnt_q[bus.op_ctx] <= cnt_d;
                if (clr)        err_q[bus.op_ctx] <= 1'b0;
                else if (fault) err_q[bus.op_ctx] <= 1'b1;
                rsp_ctx_q  <= bus.op_ctx;
                rsp_err_q  <= fault;
                rsp_data_q <= res;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CTX; i++) begin
            empty_w[i] = (cnt_q[i] == '0);
            full_w[i]  = (cnt_q[i] == CW'(DEPTH));
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_ctx   = rsp_ctx_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.err       = err_q;
    assign bus.empty     = empty_w;
    assign bus.full      = full_w;
endmodule
